// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with register file, hazard stall and branch squash
//
// Purpose: decodes the IF/ID instruction word and reads its operands from a 32x32
// register file. An optional writeback bypass is included. The stage detects
// load-use hazards and kills two wrong-path slots after a taken branch. All
// decoded fields are registered into the ID/EX pipeline register.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 active-low reset, asynchronous assert
//   if_id_instr_data    instruction word from fetch
//   if_id_pc            PC of that instruction
//   ex_if_take_branch   taken branch/jump in EX (squash)
//   wb_id_reg_write     writeback enable
//   wb_id_rd            writeback destination register
//   wb_id_data          writeback data
//   id_stall            load-use hazard; fetch holds PC and IF/ID
//   id_ex_*             ID/EX pipeline register contents
module decode_stage #(
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr_data,
  input  logic [31:0] if_id_pc,
  input  logic        ex_if_take_branch,
  input  logic        wb_id_reg_write,
  input  logic [4:0]  wb_id_rd,
  input  logic [31:0] wb_id_data,
  output logic        id_stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [6:0]  id_ex_opcode,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_funct7b5,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_reg_write
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam bit BYPASS = (WB_BYPASS != 0);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush_pending;
  logic        bubble;
  logic [31:0] regs [0:31];

  assign instr  = if_id_instr_data;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Immediate generation, sign-extended by format
  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'h000};
      OP_JAL:                   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  always_comb begin
    mem_read  = (opcode == OP_LOAD);
    mem_write = (opcode == OP_STORE);
    reg_write = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: reg_write = 1'b1;
      default:                                                 reg_write = 1'b0;
    endcase
    if (rd == 5'd0) reg_write = 1'b0;
  end

  // Only fields that are real register specifiers may raise a hazard;
  // e.g. the immediate bits of LUI overlap the rs1 field.
  assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));

  // Operand read; a same-cycle writeback wins over the stale array value
  always_comb begin
    rs1_data = regs[rs1];
    if (BYPASS && wb_id_reg_write && (wb_id_rd == rs1)) rs1_data = wb_id_data;
    if (rs1 == 5'd0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs[rs2];
    if (BYPASS && wb_id_reg_write && (wb_id_rd == rs2)) rs2_data = wb_id_data;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  // Squash takes priority: a wrong-path instruction must not hold fetch
  assign id_stall = !ex_if_take_branch && id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == id_ex_rd)) || (rs2_used && (rs2 == id_ex_rd)));

  assign bubble = ex_if_take_branch || flush_pending || id_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_id_reg_write && (wb_id_rd != 5'd0)) begin
      regs[wb_id_rd] <= wb_id_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pending   <= 1'b0;
      id_ex_valid     <= 1'b0;
      id_ex_pc        <= '0;
      id_ex_imm       <= '0;
      id_ex_rs1_data  <= '0;
      id_ex_rs2_data  <= '0;
      id_ex_rs1       <= '0;
      id_ex_rs2       <= '0;
      id_ex_rd        <= '0;
      id_ex_opcode    <= '0;
      id_ex_funct3    <= '0;
      id_ex_funct7b5  <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_reg_write <= 1'b0;
    end else begin
      // A taken branch kills this slot and the next one; a branch while
      // already pending simply re-arms the second kill.
      flush_pending   <= ex_if_take_branch;
      // Data fields always follow IF/ID; only valid and controls are bubbled
      id_ex_pc        <= if_id_pc;
      id_ex_imm       <= imm;
      id_ex_rs1_data  <= rs1_data;
      id_ex_rs2_data  <= rs2_data;
      id_ex_rs1       <= rs1;
      id_ex_rs2       <= rs2;
      id_ex_rd        <= rd;
      id_ex_opcode    <= opcode;
      id_ex_funct3    <= instr[14:12];
      id_ex_funct7b5  <= instr[30];
      id_ex_valid     <= !bubble;
      id_ex_mem_read  <= !bubble && mem_read;
      id_ex_mem_write <= !bubble && mem_write;
      id_ex_reg_write <= !bubble && reg_write;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr_data;
  logic [31:0] if_id_pc;
  logic        ex_if_take_branch;
  logic        wb_id_reg_write;
  logic [4:0]  wb_id_rd;
  logic [31:0] wb_id_data;
  logic        id_stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_imm;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic [6:0]  id_ex_opcode;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b5;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_reg_write;

  always #5 clk = ~clk;

  decode_stage #(.WB_BYPASS(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instr_data  (if_id_instr_data),
    .if_id_pc          (if_id_pc),
    .ex_if_take_branch (ex_if_take_branch),
    .wb_id_reg_write   (wb_id_reg_write),
    .wb_id_rd          (wb_id_rd),
    .wb_id_data        (wb_id_data),
    .id_stall          (id_stall),
    .id_ex_valid       (id_ex_valid),
    .id_ex_pc          (id_ex_pc),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rs1_data    (id_ex_rs1_data),
    .id_ex_rs2_data    (id_ex_rs2_data),
    .id_ex_rs1         (id_ex_rs1),
    .id_ex_rs2         (id_ex_rs2),
    .id_ex_rd          (id_ex_rd),
    .id_ex_opcode      (id_ex_opcode),
    .id_ex_funct3      (id_ex_funct3),
    .id_ex_funct7b5    (id_ex_funct7b5),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .id_ex_reg_write   (id_ex_reg_write)
  );

  typedef struct packed {
    logic        valid;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
  } obs_t;

  typedef struct packed {
    obs_t m;
    obs_t v;
  } sb_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        stall;
    obs_t        m;
    obs_t        v;
  } row_t;

  localparam obs_t M_ALL  = obs_t'({4'hF, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
  localparam obs_t M_DEC  = obs_t'({4'hF, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
  localparam obs_t M_REGS = obs_t'({4'h8, 5'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADDI_X1_M1  = 32'hFFF00093;
  localparam logic [31:0] LW_X2       = 32'h0000A103;
  localparam logic [31:0] LW_X0       = 32'h0000A003;
  localparam logic [31:0] ADD_3_2_1   = 32'h001101B3;
  localparam logic [31:0] ADD_3_0_0   = 32'h000001B3;
  localparam logic [31:0] ADD_3_1_1   = 32'h001081B3;
  localparam logic [31:0] LUI_X7_10   = 32'h000103B7;
  localparam logic [31:0] SW_X2_M4    = 32'hFE20AE23;
  localparam logic [31:0] ADD_6_5_5   = 32'h00528333;
  localparam logic [31:0] ADD_6_0_0   = 32'h00000333;
  localparam logic [31:0] ADD_6_0_5   = 32'h00500333;
  localparam logic [31:0] ADD_6_4_5   = 32'h00520333;
  localparam logic [31:0] BEQ_M4      = 32'hFE000EE3;
  localparam logic [31:0] JAL_8       = 32'h0080006F;
  localparam logic [31:0] LUI_12345   = 32'h123453B7;
  localparam logic [31:0] AUIPC_FFFFF = 32'hFFFFF417;
  localparam logic [31:0] JALR_M1     = 32'hFFF100E7;
  localparam logic [31:0] BAD_OP      = 32'hFFFFFFFF;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic obs_t obs(input logic valid, mr, mw, rw, input logic [4:0] rd,
                               input logic [31:0] pc, imm, r1, r2);
    return {valid, mr, mw, rw, rd, pc, imm, r1, r2};
  endfunction

  function automatic obs_t dut_obs();
    return {id_ex_valid, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_rd,
            id_ex_pc, id_ex_imm, id_ex_rs1_data, id_ex_rs2_data};
  endfunction

  function automatic row_t row(input logic [31:0] instr, pc, input logic br, we,
                               input logic [4:0] wrd, input logic [31:0] wd,
                               input logic stall, input obs_t m, v);
    row_t r;
    r.instr = instr; r.pc = pc; r.br = br; r.we = we; r.wrd = wrd; r.wd = wd;
    r.stall = stall; r.m = m; r.v = v;
    return r;
  endfunction

  task automatic drive(input row_t r);
    if_id_instr_data  = r.instr;
    if_id_pc          = r.pc;
    ex_if_take_branch = r.br;
    wb_id_reg_write   = r.we;
    wb_id_rd          = r.wrd;
    wb_id_data        = r.wd;
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    if_id_instr_data = '0; if_id_pc = '0; ex_if_take_branch = 1'b0;
    wb_id_reg_write = 1'b0; wb_id_rd = '0; wb_id_data = '0;
    repeat (2) @(posedge clk);
    #1;
    got = dut_obs();
    vectors++;
    if (got !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL reset id_ex: got %h expected 0", got);
    end
    vectors++;
    if (id_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset id_stall: got %b expected 0", id_stall);
    end
    rst = 1'b1;
  endtask

  task automatic test_addi();
    row_t rows[$];
    sb_t e; obs_t got;
    rows.push_back(row(ADDI_X1_5,  32'h4, 0, 0, 0, 0, 0, M_ALL, obs(1, 0, 0, 1, 1, 32'h4, 32'h5, 0, 0)));
    rows.push_back(row(ADDI_X1_M1, 32'h8, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 1, 32'h8, 32'hFFFFFFFF, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      vectors++;
      if (id_stall !== rows[i].stall) begin
        miscompares++;
        $display("FAIL addi[%0d] id_stall: got %b expected %b", i, id_stall, rows[i].stall);
      end
      sb_q.push_back('{m: rows[i].m, v: rows[i].v});
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL addi[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    sb_t e; obs_t got;
    rows.push_back(row(LW_X2,     32'h08, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 1, 2,  32'h08, 0, 0, 0)));
    rows.push_back(row(ADD_3_2_1, 32'h0C, 0, 0, 0, 0, 1, M_DEC, obs(0, 0, 0, 0, 3,  32'h0C, 0, 0, 0)));
    rows.push_back(row(ADD_3_2_1, 32'h0C, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 3,  32'h0C, 0, 0, 0)));
    rows.push_back(row(LW_X2,     32'h10, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 1, 2,  32'h10, 0, 0, 0)));
    rows.push_back(row(LUI_X7_10, 32'h14, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 7,  32'h14, 32'h10000, 0, 0)));
    rows.push_back(row(LW_X2,     32'h18, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 1, 2,  32'h18, 0, 0, 0)));
    rows.push_back(row(SW_X2_M4,  32'h1C, 0, 0, 0, 0, 1, M_DEC, obs(0, 0, 0, 0, 28, 32'h1C, 32'hFFFFFFFC, 0, 0)));
    rows.push_back(row(SW_X2_M4,  32'h1C, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 1, 0, 28, 32'h1C, 32'hFFFFFFFC, 0, 0)));
    rows.push_back(row(LW_X2,     32'h20, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 1, 2,  32'h20, 0, 0, 0)));
    rows.push_back(row(ADD_3_1_1, 32'h24, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 3,  32'h24, 0, 0, 0)));
    rows.push_back(row(LW_X0,     32'h28, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 0, 0,  32'h28, 0, 0, 0)));
    rows.push_back(row(ADD_3_0_0, 32'h2C, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 3,  32'h2C, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      vectors++;
      if (id_stall !== rows[i].stall) begin
        miscompares++;
        $display("FAIL load_use[%0d] id_stall: got %b expected %b", i, id_stall, rows[i].stall);
      end
      sb_q.push_back('{m: rows[i].m, v: rows[i].v});
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL load_use[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_squash();
    row_t rows[$];
    sb_t e; obs_t got;
    // single branch: two bubbles, then issue
    rows.push_back(row(ADDI_X1_5, 32'h30, 1, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 1, 32'h30, 5, 0, 0)));
    rows.push_back(row(ADDI_X1_5, 32'h34, 0, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 1, 32'h34, 5, 0, 0)));
    rows.push_back(row(ADDI_X1_5, 32'h38, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 1, 32'h38, 5, 0, 0)));
    // branch while flush pending re-arms
    rows.push_back(row(ADDI_X1_5, 32'h3C, 1, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 1, 32'h3C, 5, 0, 0)));
    rows.push_back(row(ADDI_X1_5, 32'h40, 1, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 1, 32'h40, 5, 0, 0)));
    rows.push_back(row(ADDI_X1_5, 32'h44, 0, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 1, 32'h44, 5, 0, 0)));
    rows.push_back(row(ADDI_X1_5, 32'h48, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 1, 32'h48, 5, 0, 0)));
    // load-use hazard coinciding with a branch: squash wins
    rows.push_back(row(LW_X2,     32'h4C, 0, 0, 0, 0, 0, M_DEC, obs(1, 1, 0, 1, 2, 32'h4C, 0, 0, 0)));
    rows.push_back(row(ADD_3_2_1, 32'h50, 1, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 3, 32'h50, 0, 0, 0)));
    rows.push_back(row(ADD_3_2_1, 32'h54, 0, 0, 0, 0, 0, M_DEC, obs(0, 0, 0, 0, 3, 32'h54, 0, 0, 0)));
    rows.push_back(row(ADD_3_2_1, 32'h58, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 3, 32'h58, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      vectors++;
      if (id_stall !== rows[i].stall) begin
        miscompares++;
        $display("FAIL squash[%0d] id_stall: got %b expected %b", i, id_stall, rows[i].stall);
      end
      sb_q.push_back('{m: rows[i].m, v: rows[i].v});
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL squash[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_wb_bypass();
    row_t rows[$];
    sb_t e; obs_t got;
    rows.push_back(row(ADD_6_5_5, 32'h60, 0, 1, 5, 32'hDEADBEEF, 0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF)));
    rows.push_back(row(ADD_6_0_0, 32'h64, 0, 1, 0, 32'h7,        0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(row(ADD_6_0_5, 32'h68, 0, 0, 0, 0,            0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF)));
    rows.push_back(row(ADD_6_5_5, 32'h6C, 0, 1, 5, 32'h12345678, 0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678)));
    rows.push_back(row(ADD_6_5_5, 32'h70, 0, 1, 4, 32'h0000AAAA, 0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678)));
    rows.push_back(row(ADD_6_4_5, 32'h74, 0, 0, 0, 0,            0, M_REGS, obs(1, 0, 0, 0, 0, 0, 0, 32'h0000AAAA, 32'h12345678)));
    foreach (rows[i]) begin
      drive(rows[i]);
      vectors++;
      if (id_stall !== rows[i].stall) begin
        miscompares++;
        $display("FAIL wb_bypass[%0d] id_stall: got %b expected %b", i, id_stall, rows[i].stall);
      end
      sb_q.push_back('{m: rows[i].m, v: rows[i].v});
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL wb_bypass[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_imm();
    row_t rows[$];
    sb_t e; obs_t got;
    rows.push_back(row(BEQ_M4,      32'h80, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 0, 29, 32'h80, 32'hFFFFFFFC, 0, 0)));
    rows.push_back(row(JAL_8,       32'h84, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 0, 0,  32'h84, 32'h00000008, 0, 0)));
    rows.push_back(row(LUI_12345,   32'h88, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 7,  32'h88, 32'h12345000, 0, 0)));
    rows.push_back(row(AUIPC_FFFFF, 32'h8C, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 8,  32'h8C, 32'hFFFFF000, 0, 0)));
    rows.push_back(row(JALR_M1,     32'h90, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 1, 1,  32'h90, 32'hFFFFFFFF, 0, 0)));
    rows.push_back(row(BAD_OP,      32'h94, 0, 0, 0, 0, 0, M_DEC, obs(1, 0, 0, 0, 31, 32'h94, 32'h00000000, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      vectors++;
      if (id_stall !== rows[i].stall) begin
        miscompares++;
        $display("FAIL imm[%0d] id_stall: got %b expected %b", i, id_stall, rows[i].stall);
      end
      sb_q.push_back('{m: rows[i].m, v: rows[i].v});
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL imm[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  // First 32 cycles load every register through WB, then random reads with
  // random concurrent writebacks are checked against a reference array.
  task automatic test_regfile_random();
    logic [31:0] mdl [32];
    logic [4:0]  ra, rb, wrd;
    logic        we;
    logic [31:0] wd, x1v, x2v, pc;
    row_t r; sb_t e; obs_t got;
    for (int k = 0; k < 32; k++) mdl[k] = '0;
    for (int i = 0; i < 72; i++) begin
      if (i < 32) begin
        ra = 5'd0; rb = 5'd0; we = 1'b1; wrd = i[4:0];
      end else begin
        ra  = 5'($urandom_range(0, 31));
        rb  = 5'($urandom_range(0, 31));
        we  = 1'($urandom_range(0, 1));
        wrd = 5'($urandom_range(0, 31));
      end
      wd  = $urandom;
      pc  = 32'h100 + 32'(i) * 4;
      x1v = (we && wrd != 5'd0 && wrd == ra) ? wd : mdl[ra];
      x2v = (we && wrd != 5'd0 && wrd == rb) ? wd : mdl[rb];
      r = row({7'b0, rb, ra, 3'b000, 5'd6, 7'b0110011}, pc, 0, we, wrd, wd, 0,
              M_ALL, obs(1, 0, 0, 1, 6, pc, 0, x1v, x2v));
      drive(r);
      vectors++;
      if (id_stall !== r.stall) begin
        miscompares++;
        $display("FAIL regfile[%0d] id_stall: got %b expected %b", i, id_stall, r.stall);
      end
      sb_q.push_back('{m: r.m, v: r.v});
      @(posedge clk); #1;
      if (we && wrd != 5'd0) mdl[wrd] = wd;
      e = sb_q.pop_front(); got = dut_obs(); vectors++;
      if ((got & e.m) !== (e.v & e.m)) begin
        miscompares++;
        $display("FAIL regfile[%0d] id_ex: got %h expected %h", i, got & e.m, e.v & e.m);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    // leave a non-zero bubble in ID/EX with flush pending
    drive(row(ADDI_X1_5, 32'hA0, 1, 0, 0, 0, 0, M_ALL, '0));
    @(posedge clk); #1;
    drive(row(ADD_6_5_5, 32'hA4, 0, 0, 0, 0, 0, M_ALL, '0));
    #2;
    rst = 1'b0;
    #1;
    got = dut_obs();
    vectors++;
    if (got !== obs_t'(0)) begin
      miscompares++;
      $display("FAIL async_reset id_ex: got %h expected 0", got);
    end
    vectors++;
    if (id_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset id_stall: got %b expected 0", id_stall);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    // flush_pending and registers must both be cleared
    sb_q.push_back('{m: M_ALL, v: obs(1, 0, 0, 1, 6, 32'hA4, 0, 0, 0)});
    @(posedge clk); #1;
    got = dut_obs();
    vectors++;
    if ((got & sb_q[0].m) !== (sb_q[0].v & sb_q[0].m)) begin
      miscompares++;
      $display("FAIL async_reset release: got %h expected %h", got, sb_q[0].v);
    end
    void'(sb_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_squash();
    test_wb_bypass();
    test_imm();
    test_regfile_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
